// File: rtl/dff_pkg.sv
// Shared constants for the clearable, loadable register family.
package dff_pkg;

   localparam int                   DFF_WIDTH   = 4;
   localparam logic                 CLR_ACTIVE  = 1'b0;
   localparam logic [DFF_WIDTH-1:0] DFF_RST_VAL = {DFF_WIDTH{1'b0}};

endpackage

// File: rtl/dff1_ce.sv
// Single-bit register cell: async active-low clear, then clock enable, then hold.
module dff1_ce
   import dff_pkg::*;
#(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic clr,
   input  logic ce,
   input  logic d,
   output logic q
);

   // The enable is a feedback mux in front of the flop; the clock is never gated.
   always_ff @(posedge clk or negedge clr) begin
      if (clr == CLR_ACTIVE) begin
         q <= RST_VAL;
      end else if (ce) begin
         q <= d;
      end
   end

endmodule

// File: rtl/dff4_ce.sv
// WIDTH-bit register with clock enable and asynchronous active-low clear,
// built from independent single-bit cells; q comes straight from the flops.
module dff4_ce
   import dff_pkg::*;
#(
   parameter int               WIDTH   = DFF_WIDTH,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             ce,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      dff1_ce #(
         .RST_VAL (RST_VAL[i])
      ) u_cell (
         .clk (clk),
         .clr (clr),
         .ce  (ce),
         .d   (d[i]),
         .q   (q[i])
      );
   end

endmodule

// File: tb/tb_dff4_ce.sv
// Directed plus random bench for dff4_ce; a second instance uses a non-zero
// clear value so each bit's clear value is exercised individually.
module tb_dff4_ce;

   localparam int         W  = 4;
   localparam logic [W-1:0] RV = 4'b1010;

   logic         clk;
   logic         clr;
   logic         ce;
   logic [W-1:0] d;
   logic [W-1:0] q;
   logic [W-1:0] q_rv;

   logic [2*W-1:0] exp_q[$];
   logic [W-1:0]   m0;
   logic [W-1:0]   m1;
   int             n_total;
   int             n_pass;

   dff4_ce #(.WIDTH(W)) dut (
      .clk (clk),
      .clr (clr),
      .ce  (ce),
      .d   (d),
      .q   (q)
   );

   dff4_ce #(.WIDTH(W), .RST_VAL(RV)) dut_rv (
      .clk (clk),
      .clr (clr),
      .ce  (ce),
      .d   (d),
      .q   (q_rv)
   );

   // clock: 20 ns period, starts low, first rising edge at 10 ns
   initial clk = 1'b0;
   always #10 clk = ~clk;

   task automatic apply(input logic c, input logic e, input logic [W-1:0] dd);
      clr = c;
      ce  = e;
      d   = dd;
      if (!c) begin
         m0 = '0;
         m1 = RV;
      end
   endtask

   task automatic push_now();
      exp_q.push_back({m1, m0});
   endtask

   task automatic push_edge();
      if (clr && ce) begin
         m0 = d;
         m1 = d;
      end
      exp_q.push_back({m1, m0});
   endtask

   task automatic check(input string tag);
      logic [2*W-1:0] exp;
      n_total++;
      if (exp_q.size() == 0) begin
         $error("FAIL %s: scoreboard empty, observed %b", tag, {q_rv, q});
      end else begin
         exp = exp_q.pop_front();
         assert ({q_rv, q} === exp) n_pass++;
         else $error("FAIL %s: observed q_rv/q=%b/%b expected %b/%b",
                     tag, q_rv, q, exp[2*W-1:W], exp[W-1:0]);
      end
   endtask

   // drive on the current (falling) edge, check 1 ns after the next rising edge
   task automatic step(input logic c, input logic e, input logic [W-1:0] dd,
                       input string tag);
      apply(c, e, dd);
      push_edge();
      @(posedge clk);
      #1;
      check(tag);
      @(negedge clk);
   endtask

   initial begin
      n_total = 0;
      n_pass  = 0;
      m0 = 'x;
      m1 = 'x;

      step(1'b1, 1'b1, 4'b1111, "load");
      step(1'b1, 1'b0, 4'b1010, "hold");

      apply(1'b0, 1'b1, 4'b0101);
      push_now();
      #1;
      check("clr_async");
      push_edge();
      @(posedge clk);
      #1;
      check("clr_over_ce");
      @(negedge clk);

      step(1'b0, 1'b0, 4'b0001, "clr_held");
      step(1'b1, 1'b0, 4'b0110, "release_hold");
      step(1'b1, 1'b1, 4'b0110, "release_load");
      step(1'b1, 1'b1, 4'b1001, "load_1001");

      // 3 ns clear pulse in the middle of the low phase
      ce = 1'b0;
      #4;
      apply(1'b0, 1'b0, d);
      push_now();
      #1;
      check("mid_clr");
      #2;
      clr = 1'b1;
      push_now();
      #1;
      check("mid_release");
      step(1'b1, 1'b0, 4'b0111, "mid_hold");
      step(1'b1, 1'b1, 4'b1100, "mid_reload");

      for (int i = 0; i < 24; i++) begin
         step(($urandom_range(0, 4) != 0), 1'($urandom_range(0, 1)),
              W'($urandom_range(0, 15)), $sformatf("rand_%0d", i));
      end

      // final clear and release: both instances back to their clear values
      step(1'b0, 1'b1, 4'b1111, "final_clr");
      step(1'b1, 1'b0, 4'b0011, "final_hold");

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
